// File: rtl/spi_ram_sp.sv
// Single-port byte RAM behind the SPI slave: decodes 2-bit commands from the
// 10-bit rx word stream and returns read bytes as a one-cycle tx_valid pulse.
module spi_ram_sp #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
);

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  logic [7:0]           mem [0:MEM_DEPTH-1];

  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]           dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 mem_we;
  cmd_e                 cmd;

  assign cmd = cmd_e'(din[9:8]);

  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = dout_q;
    tx_valid_d = 1'b0;
    mem_we     = 1'b0;
    if (rx_valid) begin
      case (cmd)
        CMD_WR_ADDR: wr_addr_d = din[ADDR_SIZE-1:0];
        CMD_WR_DATA: begin
          mem_we = 1'b1;
          if (AUTO_INC != 0) wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
        end
        CMD_RD_ADDR: rd_addr_d = din[ADDR_SIZE-1:0];
        CMD_RD_DATA: begin
          dout_d     = mem[rd_addr_q];
          tx_valid_d = 1'b1;
          if (AUTO_INC != 0) rd_addr_d = rd_addr_q + ADDR_SIZE'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Storage is never reset; a write arriving while reset is held is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) mem[wr_addr_q] <= din[7:0];
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_spi_ram_sp.sv
// Scoreboard bench for spi_ram_sp: one instance without and one with
// pointer auto-increment, both fed the same command stream.
module tb_spi_ram_sp;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout0, dout1;
  logic       tx_valid0, tx_valid1;

  always #5 clk = ~clk;

  spi_ram_sp #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) u_ram0 (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout0), .tx_valid(tx_valid0));

  spi_ram_sp #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) u_ram1 (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout1), .tx_valid(tx_valid1));

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: index 0 = no auto-increment, index 1 = auto-increment.
  logic [7:0] m_mem [2][256];
  int         m_wr  [2];
  int         m_rd  [2];
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  logic [7:0] last_dout [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_apply(input logic [1:0] c, input logic [7:0] p);
    for (int i = 0; i < 2; i++) begin
      case (c)
        2'b00: m_wr[i] = int'(p);
        2'b01: begin
          m_mem[i][m_wr[i]] = p;
          if (i == 1) m_wr[i] = (m_wr[i] + 1) % 256;
        end
        2'b10: m_rd[i] = int'(p);
        default: begin
          if (i == 0) exp_q0.push_back(m_mem[0][m_rd[0]]);
          else        exp_q1.push_back(m_mem[1][m_rd[1]]);
          if (i == 1) m_rd[i] = (m_rd[i] + 1) % 256;
        end
      endcase
    end
  endtask

  // Present one command for one clock edge; returns 2 time units after that edge.
  task automatic cmd(input logic [1:0] c, input logic [7:0] p);
    din      = {c, p};
    rx_valid = 1'b1;
    model_apply(c, p);
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    din      = $urandom_range(0, 1023);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // Monitor: every read pulse must match the oldest expected byte; between
  // pulses dout must hold the last delivered byte.
  always @(negedge clk) begin
    if (tx_valid0) begin
      if (exp_q0.size() == 0) chk("ram0_unexpected_tx_valid", 1, 0);
      else begin
        last_dout[0] = exp_q0.pop_front();
        chk("ram0_read_data", dout0, last_dout[0]);
      end
    end else chk("ram0_dout_hold", dout0, last_dout[0]);
    if (tx_valid1) begin
      if (exp_q1.size() == 0) chk("ram1_unexpected_tx_valid", 1, 0);
      else begin
        last_dout[1] = exp_q1.pop_front();
        chk("ram1_read_data", dout1, last_dout[1]);
      end
    end else chk("ram1_dout_hold", dout1, last_dout[1]);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] c;
    rst_n        = 1'b0;
    rx_valid     = 1'b0;
    din          = '0;
    last_dout[0] = 8'h00;
    last_dout[1] = 8'h00;
    for (int i = 0; i < 2; i++) begin m_wr[i] = 0; m_rd[i] = 0; end
    #1;
    chk("reset_tx_valid0", tx_valid0, 0);
    chk("reset_dout0", dout0, 8'h00);
    chk("reset_tx_valid1", tx_valid1, 0);
    chk("reset_dout1", dout1, 8'h00);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Define every location so the model knows all contents.
    for (int a = 0; a < 256; a++) begin
      cmd(2'b00, 8'(a));
      cmd(2'b01, 8'($urandom_range(0, 255)));
    end

    // Basic write/read, then dout holds after the pulse.
    cmd(2'b00, 8'h3C); cmd(2'b01, 8'hA5); cmd(2'b10, 8'h3C); cmd(2'b11, 8'h00);
    idle(3);
    chk("basic_hold_dout0", dout0, 8'hA5);
    chk("basic_hold_tx_valid0", tx_valid0, 0);

    // Interleaved write and read pointers.
    cmd(2'b00, 8'h10); cmd(2'b01, 8'h11); cmd(2'b10, 8'h20);
    cmd(2'b01, 8'h22); cmd(2'b11, 8'h00);
    cmd(2'b10, 8'h10); cmd(2'b11, 8'h00);
    idle(2);

    // Read-after-write in consecutive cycles.
    cmd(2'b00, 8'h07); cmd(2'b01, 8'h5A); cmd(2'b10, 8'h07); cmd(2'b11, 8'h00);
    idle(1);
    chk("raw_dout0", dout0, 8'h5A);

    // Wrap at the top of memory, then three back-to-back reads.
    cmd(2'b00, 8'hFE); cmd(2'b01, 8'h01); cmd(2'b01, 8'h02); cmd(2'b01, 8'h03);
    cmd(2'b10, 8'hFE); cmd(2'b11, 8'h00); cmd(2'b11, 8'h00); cmd(2'b11, 8'h00);
    idle(1);
    chk("wrap_last_dout1", dout1, 8'h03);

    // Long idle gap: monitor flags any spurious pulse or dout change.
    idle(20);

    // Repeated reads with no new address.
    cmd(2'b11, 8'h00); cmd(2'b11, 8'h00); idle(2);

    // Randomized traffic with occasional idle gaps.
    for (int n = 0; n < 2000; n++) begin
      c = 2'($urandom_range(0, 3));
      cmd(c, 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 4));
    end
    idle(2);

    // Reset asserted while a read pulse is in flight, with a write held on rx.
    cmd(2'b10, 8'h33);
    cmd(2'b11, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("midreset_tx_valid0", tx_valid0, 0);
    chk("midreset_dout0", dout0, 8'h00);
    chk("midreset_tx_valid1", tx_valid1, 0);
    chk("midreset_dout1", dout1, 8'h00);
    exp_q0.delete();
    exp_q1.delete();
    last_dout[0] = 8'h00;
    last_dout[1] = 8'h00;
    for (int i = 0; i < 2; i++) begin m_wr[i] = 0; m_rd[i] = 0; end
    din      = {2'b01, 8'hEE};
    rx_valid = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rx_valid = 1'b0;
    rst_n    = 1'b1;
    idle(1);
    // Both pointers restart at 0 after reset.
    cmd(2'b11, 8'h00);
    cmd(2'b01, 8'h6D);
    cmd(2'b11, 8'h00);
    idle(3);

    chk("ram0_all_reads_seen", exp_q0.size(), 0);
    chk("ram1_all_reads_seen", exp_q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
